// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Round-robin grant, registered write stage, pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic [(1<<AW)-1:0]   busy,
  output logic                 we,
  output logic [AW-1:0]        a3,
  output logic [XLEN-1:0]      wd3
);

  localparam int LW  = $clog2(NREQ);
  localparam int NRG = 1 << AW;

  logic [LW-1:0]   last_q, last_d;
  logic            we_q, we_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic [NRG-1:0]  busy_q, busy_d;

  logic [NREQ-1:0] gnt;
  logic [LW-1:0]   win;
  logic            found;
  logic [AW-1:0]   win_addr;
  logic [XLEN-1:0] win_data;
  int              idx;

  // Round-robin search starting just after the last winner
  always_comb begin
    gnt      = '0;
    win      = '0;
    found    = 1'b0;
    win_addr = '0;
    win_data = '0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        win      = LW'(idx);
        gnt[idx] = 1'b1;
        win_addr = req_addr[idx*AW +: AW];
        win_data = req_data[idx*XLEN +: XLEN];
      end
    end
  end

  assign req_ready = gnt;

  // Next state of write stage and arbiter pointer
  always_comb begin
    last_d = found ? win : last_q;
    we_d   = found && (win_addr != '0);
    a3_d   = we_d ? win_addr : a3_q;
    wd3_d  = we_d ? win_data : wd3_q;
  end

  // Scoreboard: reserve wins over the commit on the same edge
  always_comb begin
    busy_d = busy_q;
    busy_d[0] = 1'b0;
    for (int r = 1; r < NRG; r++) begin
      if (rsv_valid && rsv_addr == AW'(r)) begin
        busy_d[r] = 1'b1;
      end else if (we_q && a3_q == AW'(r)) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= LW'(NREQ - 1);
      we_q   <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      busy_q <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      busy_q <= busy_d;
    end
  end

  assign we   = we_q;
  assign a3   = a3_q;
  assign wd3  = wd3_q;
  assign busy = busy_q;

endmodule
